// File: rtl/display_page_sequencer.sv
// Page sequencer for the 4-digit seven-segment debug display: button debounce,
// auto-scroll timer, page counter with one-hot LEDs and a freezable value register.
module display_page_sequencer #(
  parameter int DEB_CYCLES = 1000000,
  parameter int AUTO_BITS  = 27
) (
  input  logic        clk1,
  input  logic        rst,
  input  logic        btn_next,
  input  logic        auto_en,
  input  logic        freeze,
  input  logic [31:0] src0,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic [31:0] src3,
  output logic [15:0] disp_val,
  output logic [2:0]  page,
  output logic [7:0]  page_led,
  output logic        frozen
);

  localparam int DW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

  logic                 sync1_q, sync2_q;
  logic                 btn_db_q, btn_db_d;
  logic                 btn_db_prev_q;
  logic [DW-1:0]        deb_cnt_q, deb_cnt_d;
  logic [AUTO_BITS-1:0] timer_q, timer_d;
  logic [2:0]           page_q, page_d;
  logic [7:0]           page_led_q;
  logic [15:0]          disp_q, disp_d;
  logic                 page_chg_q;
  logic                 frozen_q;

  logic                 next_pulse_s;
  logic                 auto_tick_s;
  logic                 advance_s;
  logic                 load_en_s;
  logic [31:0]          word_s;
  logic [15:0]          half_s;

  // Next-state logic for debounce, auto timer, page and display value
  always_comb begin
    next_pulse_s = btn_db_q & ~btn_db_prev_q;
    // The tick only fires while the timer is actually counting, so a held
    // all-ones value during freeze cannot produce repeated advances.
    auto_tick_s  = auto_en & ~freeze & (&timer_q);
    advance_s    = next_pulse_s | auto_tick_s;
    load_en_s    = ~freeze | page_chg_q;

    btn_db_d  = btn_db_q;
    deb_cnt_d = '0;
    if (sync2_q != btn_db_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        btn_db_d  = sync2_q;
        deb_cnt_d = '0;
      end else begin
        btn_db_d  = btn_db_q;
        deb_cnt_d = deb_cnt_q + DW'(1);
      end
    end else begin
      btn_db_d  = btn_db_q;
      deb_cnt_d = '0;
    end

    timer_d = timer_q;
    if (!auto_en || next_pulse_s) begin
      timer_d = '0;
    end else if (freeze) begin
      timer_d = timer_q;
    end else begin
      timer_d = timer_q + AUTO_BITS'(1);
    end

    page_d = page_q;
    if (advance_s) begin
      page_d = page_q + 3'd1;
    end else begin
      page_d = page_q;
    end

    word_s = 32'h0000_0000;
    case (page_q[2:1])
      2'd0:    word_s = src0;
      2'd1:    word_s = src1;
      2'd2:    word_s = src2;
      2'd3:    word_s = src3;
      default: word_s = 32'h0000_0000;
    endcase
    half_s = page_q[0] ? word_s[31:16] : word_s[15:0];

    disp_d = disp_q;
    if (load_en_s) begin
      disp_d = half_s;
    end else begin
      disp_d = disp_q;
    end
  end

  // State registers with asynchronous active-high clear
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      btn_db_q      <= 1'b0;
      btn_db_prev_q <= 1'b0;
      deb_cnt_q     <= '0;
      timer_q       <= '0;
      page_q        <= 3'd0;
      page_led_q    <= 8'h01;
      disp_q        <= 16'h0000;
      page_chg_q    <= 1'b0;
      frozen_q      <= 1'b0;
    end else begin
      sync1_q       <= btn_next;
      sync2_q       <= sync1_q;
      btn_db_q      <= btn_db_d;
      btn_db_prev_q <= btn_db_q;
      deb_cnt_q     <= deb_cnt_d;
      timer_q       <= timer_d;
      page_q        <= page_d;
      page_led_q    <= 8'h01 << page_d;
      disp_q        <= disp_d;
      page_chg_q    <= advance_s;
      frozen_q      <= freeze;
    end
  end

  assign disp_val = disp_q;
  assign page     = page_q;
  assign page_led = page_led_q;
  assign frozen   = frozen_q;

endmodule

// File: tb/tb_display_page_sequencer.sv
// Directed bench for display_page_sequencer with DEB_CYCLES=4, AUTO_BITS=4.
module tb_display_page_sequencer;

  logic        clk1 = 1'b0;
  logic        rst;
  logic        btn_next;
  logic        auto_en;
  logic        freeze;
  logic [31:0] src0, src1, src2, src3;
  logic [15:0] disp_val;
  logic [2:0]  page;
  logic [7:0]  page_led;
  logic        frozen;

  int n_vec = 0;
  int n_err = 0;

  display_page_sequencer #(.DEB_CYCLES(4), .AUTO_BITS(4)) dut (
    .clk1(clk1), .rst(rst), .btn_next(btn_next), .auto_en(auto_en),
    .freeze(freeze), .src0(src0), .src1(src1), .src2(src2), .src3(src3),
    .disp_val(disp_val), .page(page), .page_led(page_led), .frozen(frozen)
  );

  always #5 clk1 = ~clk1;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk1);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(1);
  endtask

  task automatic press(input int hold, input int gap);
    btn_next = 1'b1;
    step(hold);
    btn_next = 1'b0;
    step(gap);
  endtask

  task automatic test_reset();
    src0 = 32'hDEADBEEF;
    rst  = 1'b1;
    step(1);
    rst = 1'b0;
    n_vec++;
    if (disp_val !== 16'h0000) begin n_err++; $display("FAIL rst_disp got %h want 0000", disp_val); end
    step(1);
    n_vec++;
    if (disp_val !== 16'hBEEF) begin n_err++; $display("FAIL rst_load got %h want BEEF", disp_val); end
    freeze = 1'b1;
    step(1);
    n_vec++;
    if (frozen !== 1'b1) begin n_err++; $display("FAIL frozen_set got %b want 1", frozen); end
    #3 rst = 1'b1;
    #1;
    n_vec++;
    if (page !== 3'd0 || page_led !== 8'h01 || disp_val !== 16'h0000 || frozen !== 1'b0) begin
      n_err++;
      $display("FAIL async_rst got page=%0d led=%h disp=%h frz=%b want 0 01 0000 0", page, page_led, disp_val, frozen);
    end
    freeze = 1'b0;
    #1 rst = 1'b0;
    step(1);
  endtask

  task automatic test_debounce();
    btn_next = 1'b1;
    step(3);
    btn_next = 1'b0;
    step(10);
    n_vec++;
    if (page !== 3'd0) begin n_err++; $display("FAIL glitch got page %0d want 0", page); end
    btn_next = 1'b1;
    step(6);
    n_vec++;
    if (page !== 3'd0) begin n_err++; $display("FAIL press_early got page %0d want 0", page); end
    step(1);
    n_vec++;
    if (page !== 3'd1 || page_led !== 8'h02) begin
      n_err++; $display("FAIL press_latency got page=%0d led=%h want 1 02", page, page_led);
    end
    step(1);
    n_vec++;
    if (disp_val !== 16'hDEAD) begin n_err++; $display("FAIL press_disp got %h want DEAD", disp_val); end
    step(2);
    btn_next = 1'b0;
    step(10);
    n_vec++;
    if (page !== 3'd1) begin n_err++; $display("FAIL press_once got page %0d want 1", page); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_led;
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      press(10, 10);
      exp_led = 8'h01 << (i % 8);
      n_vec++;
      if (page !== 3'(i % 8) || page_led !== exp_led) begin
        n_err++;
        $display("FAIL wrap_%0d got page=%0d led=%h want %0d %h", i, page, page_led, i % 8, exp_led);
      end
    end
  endtask

  task automatic test_auto();
    do_reset();
    auto_en = 1'b1;
    step(15);
    n_vec++;
    if (page !== 3'd0) begin n_err++; $display("FAIL auto_early got %0d want 0", page); end
    step(1);
    n_vec++;
    if (page !== 3'd1) begin n_err++; $display("FAIL auto_tick got %0d want 1", page); end
    step(3);
    btn_next = 1'b1;
    step(6);
    n_vec++;
    if (page !== 3'd1) begin n_err++; $display("FAIL man9_early got %0d want 1", page); end
    step(1);
    n_vec++;
    if (page !== 3'd2) begin n_err++; $display("FAIL man9 got %0d want 2", page); end
    step(3);
    btn_next = 1'b0;
    step(12);
    n_vec++;
    if (page !== 3'd2) begin n_err++; $display("FAIL restart_early got %0d want 2", page); end
    step(1);
    n_vec++;
    if (page !== 3'd3) begin n_err++; $display("FAIL restart got %0d want 3", page); end
    step(9);
    btn_next = 1'b1;
    step(7);
    n_vec++;
    if (page !== 3'd4) begin n_err++; $display("FAIL coincide got %0d want 4", page); end
    step(3);
    btn_next = 1'b0;
    step(12);
    n_vec++;
    if (page !== 3'd4) begin n_err++; $display("FAIL after_co_early got %0d want 4", page); end
    step(1);
    n_vec++;
    if (page !== 3'd5) begin n_err++; $display("FAIL after_co got %0d want 5", page); end
    auto_en = 1'b0;
    step(1);
  endtask

  task automatic test_freeze();
    src1 = 32'h12345678;
    do_reset();
    press(10, 10);
    press(10, 10);
    n_vec++;
    if (page !== 3'd2 || disp_val !== 16'h5678) begin
      n_err++; $display("FAIL frz_setup got page=%0d disp=%h want 2 5678", page, disp_val);
    end
    freeze = 1'b1;
    step(1);
    src1 = 32'h1234ABCD;
    auto_en = 1'b1;
    step(40);
    n_vec++;
    if (disp_val !== 16'h5678 || page !== 3'd2 || frozen !== 1'b1) begin
      n_err++; $display("FAIL frz_hold got disp=%h page=%0d frz=%b want 5678 2 1", disp_val, page, frozen);
    end
    btn_next = 1'b1;
    step(7);
    n_vec++;
    if (page !== 3'd3 || disp_val !== 16'h5678) begin
      n_err++; $display("FAIL frz_adv got page=%0d disp=%h want 3 5678", page, disp_val);
    end
    step(2);
    n_vec++;
    if (disp_val !== 16'h1234) begin n_err++; $display("FAIL frz_snap got %h want 1234", disp_val); end
    src1 = 32'h99990000;
    step(1);
    btn_next = 1'b0;
    step(20);
    n_vec++;
    if (disp_val !== 16'h1234 || page !== 3'd3) begin
      n_err++; $display("FAIL frz_keep got disp=%h page=%0d want 1234 3", disp_val, page);
    end
    freeze  = 1'b0;
    auto_en = 1'b0;
    step(1);
  endtask

  task automatic test_rst_debounce();
    do_reset();
    press(10, 10);
    btn_next = 1'b1;
    step(4);
    #3 rst = 1'b1;
    #1;
    n_vec++;
    if (page !== 3'd0 || page_led !== 8'h01) begin
      n_err++; $display("FAIL rst_mid got page=%0d led=%h want 0 01", page, page_led);
    end
    #2 rst = 1'b0;
    step(6);
    n_vec++;
    if (page !== 3'd0) begin n_err++; $display("FAIL requal_early got %0d want 0", page); end
    step(1);
    n_vec++;
    if (page !== 3'd1) begin n_err++; $display("FAIL requal got %0d want 1", page); end
    btn_next = 1'b0;
    step(10);
    n_vec++;
    if (page !== 3'd1) begin n_err++; $display("FAIL requal_once got %0d want 1", page); end
  endtask

  initial begin
    rst      = 1'b1;
    btn_next = 1'b0;
    auto_en  = 1'b0;
    freeze   = 1'b0;
    src0     = 32'h0000_0000;
    src1     = 32'h0000_0000;
    src2     = 32'hCAFE_F00D;
    src3     = 32'h0BAD_BEEF;
    test_reset();
    test_debounce();
    test_wrap();
    test_auto();
    test_freeze();
    test_rst_debounce();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/display_page_sequencer.md
Name: display_page_sequencer

Overview:
Controller that feeds the 4-digit seven-segment display path. It selects one 16-bit half-word from four 32-bit processor debug sources, such as PC, ALU result, register read data and memory data. Pages advance on a debounced push-button or an auto-scroll timer, and the displayed value can be frozen. Its disp_val output drives the 16-bit value input of the segment decoder/mux stage, and page_led drives the board LEDs so the user can see which page is shown.

Parameters:
DEB_CYCLES, 1000000, consecutive stable cycles required before the button level is accepted (10 ms at 100 MHz); minimum 2.
AUTO_BITS, 27, auto-advance period of 2^AUTO_BITS cycles (about 1.34 s at 100 MHz); minimum 2.

Ports:
clk1  input  1  system clock (100 MHz board clock)
rst  input  1  asynchronous, active-high reset
btn_next  input  1  raw push-button, asynchronous to clk1 and bouncy
auto_en  input  1  switch: 1 enables auto-scroll
freeze  input  1  switch: 1 holds the displayed value
src0  input  32  debug source 0
src1  input  32  debug source 1
src2  input  32  debug source 2
src3  input  32  debug source 3
disp_val  output  16  registered value sent to the display path
page  output  3  current page; page[2:1] is the source index, page[0] is the half (0 = bits 15:0, 1 = bits 31:16)
page_led  output  8  one-hot copy of page (bit n set when page == n)
frozen  output  1  registered copy of freeze

Behaviour:
- Clock and reset: one clock, clk1. rst is asynchronous and active-high, and every flop clears immediately when it asserts.
- Reset values:
  - page = 0, page_led = 8'h01, disp_val = 16'h0000, frozen = 0.
  - Synchroniser flops, debounced level, debounce counter and auto timer all = 0.
- Button synchroniser: btn_next passes through a 2-flop synchroniser, giving btn_s.
- Debounce:
  - A counter increments while btn_s differs from the debounced level btn_db.
  - The counter resets to 0 on any cycle where btn_s equals btn_db.
  - When the counter reaches DEB_CYCLES-1, btn_db takes btn_s and the counter clears.
  - Any glitch shorter than DEB_CYCLES cycles is ignored.
- Next pulse: next_pulse is a one-cycle pulse on the rising edge of btn_db. Release never advances the page.
- Press latency: from a clean btn_next rise to the page update is 2 (sync) + DEB_CYCLES + 1 cycles.
- Auto timer (AUTO_BITS wide):
  - Counts when auto_en=1 and freeze=0.
  - Holds its value when freeze=1.
  - Clears to 0 when auto_en=0 or next_pulse=1.
  - Produces auto_tick on the cycle it equals all-ones, then wraps to 0.
- Page counter:
  - Increments by 1 on next_pulse or auto_tick, wrapping 7 -> 0.
  - If both occur in the same cycle, it increments once only.
  - Manual advance is allowed while frozen.
- page_led is registered and is updated in the same cycle as page, so it is always one-hot and consistent with page.
- Display register:
  - Each cycle, disp_val loads the selected half of src[page[2:1]] when load_en is true.
  - load_en = ~freeze OR page_chg.
  - page_chg is a 1-cycle-delayed flag set on the cycle after page changes.
  - Normal latency: a source change appears on disp_val 1 cycle later.
  - After a page change, the new half-word appears 2 cycles after the page advance.
  - While frozen, a page change therefore loads exactly one snapshot of the new page, then holds it.
- frozen = freeze, registered with 1 cycle of delay.
- Reset mid-operation: page returns to 0 and any partially debounced press is discarded. After rst deasserts, the button must be re-qualified for the full DEB_CYCLES.
- The button held continuously produces exactly one advance; there is no auto-repeat.

Test Plan:
(Bench uses DEB_CYCLES=4, AUTO_BITS=4.)
1. Reset: assert rst asynchronously mid-cycle -> page=0, page_led=8'h01 and disp_val=0 immediately. After release with src0=32'hDEADBEEF, disp_val=16'hBEEF 1 cycle later.
2. Debounce: a 3-cycle btn_next glitch -> no page change. A clean press held for 10 cycles -> page 0->1 exactly once, and disp_val=16'hDEAD.
3. Wrap: 8 clean presses starting from page 0 -> page sequence 1..7,0, with page_led following the one-hot pattern 02,04,...,80,01.
4. Auto-scroll: auto_en=1, freeze=0 -> page advances every 16 cycles. A manual press at timer value 9 advances once and restarts the 16-cycle period. Auto tick and next_pulse in the same cycle -> a single increment.
5. Freeze: freeze=1 on page 2 with src1=32'h12345678 -> disp_val holds 16'h5678 while src1 changes and auto-scroll stops. A manual press -> page 3, disp_val=16'h1234 (snapshot of the new src1 value) and then holds.
6. Reset during debounce: start a press, assert rst at debounce count 2 -> no advance after release; the press must be re-held for the full 4 cycles.
